// File: rtl/mem_io_bridge.sv
// mem_io_bridge: CPU memory port to async SRAM, plus one memory-mapped I/O word (switches/hex).
// Latency: WAIT_STATES+1 cycles for SRAM and 1 cycle for I/O; mem_ready is held until mem_mem_ena drops.
// Backpressure: one request at a time. Optional MEM_IO_ACC_CNT_EN adds the acc_cnt completed-access counter.
module mem_io_bridge #(
    parameter int                  DATA_WIDTH  = 16,
    parameter int                  ADDR_WIDTH  = 16,
    parameter int                  WAIT_STATES = 2,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR   = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_mem_ena,
    input  logic                  mem_wr_ena,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    input  logic [DATA_WIDTH-1:0] sw_i,
    output logic [DATA_WIDTH-1:0] hex_o
`ifdef MEM_IO_ACC_CNT_EN
    ,
    output logic [15:0]           acc_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    localparam bit         FAST     = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = FAST ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] hex_q, hex_d;
    logic [DATA_WIDTH-1:0] sw_meta_q, sw_meta_d;
    logic [DATA_WIDTH-1:0] sw_sync_q, sw_sync_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        hex_d      = hex_q;
        sw_meta_d  = sw_i;
        sw_sync_d  = sw_meta_q;
        mem_ready  = 1'b0;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        case (state_q)
            IDLE: begin
                if (mem_mem_ena) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wr_d    = mem_wr_ena;
                    if (mem_addr == IO_ADDR) begin
                        state_d = HOLD;
                        if (mem_wr_ena) hex_d   = mem_wdata;
                        else            rdata_d = sw_sync_q;
                    end else if (FAST) begin
                        // Zero-wait SRAM: strobe straight from the live request for this one cycle.
                        state_d    = HOLD;
                        sram_addr  = mem_addr;
                        sram_wdata = mem_wdata;
                        sram_ce_n  = 1'b0;
                        if (mem_wr_ena) begin
                            sram_we_n = 1'b0;
                        end else begin
                            sram_oe_n = 1'b0;
                            rdata_d   = sram_rdata;
                        end
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                sram_ce_n = 1'b0;
                if (wr_q) sram_we_n = 1'b0;
                else      sram_oe_n = 1'b0;
                if (cnt_q == 4'd0) begin
                    if (!wr_q) rdata_d = sram_rdata;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                mem_ready = 1'b1;
                if (!mem_mem_ena) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            hex_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rdata_q   <= rdata_d;
            hex_q     <= hex_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign hex_o     = hex_q;

`ifdef MEM_IO_ACC_CNT_EN
    logic [15:0] acc_cnt_q, acc_cnt_d;

    // Every completed access passes through exactly one entry into HOLD.
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (state_q != HOLD && state_d == HOLD) acc_cnt_d = acc_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) acc_cnt_q <= '0;
        else        acc_cnt_q <= acc_cnt_d;
    end

    assign acc_cnt = acc_cnt_q;
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed scenarios then random accesses against a word-level reference model.
module tb_mem_io_bridge;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_mem_ena = 1'b0;
    logic        mem_wr_ena = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [15:0] sw_i = '0;
    logic [15:0] hex_o;
`ifdef MEM_IO_ACC_CNT_EN
    logic [15:0] acc_cnt;
`endif

    mem_io_bridge dut (
        .clk(clk), .reset(reset),
        .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sw_i(sw_i), .hex_o(hex_o)
`ifdef MEM_IO_ACC_CNT_EN
        , .acc_cnt(acc_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: a write commits when a full-width WE pulse ends; a truncated pulse is discarded.
    logic [15:0] sram_mem [0:255];
    bit          sram_init = 1'b0;
    int          pulse_len = 0;
    logic [15:0] pend_addr, pend_data;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0000;
            sram_init = 1'b1;
        end
        if (!sram_ce_n && !sram_we_n) begin
            pulse_len = pulse_len + 1;
            pend_addr = sram_addr;
            pend_data = sram_wdata;
        end else begin
            if (pulse_len >= WS) sram_mem[pend_addr[7:0]] = pend_data;
            pulse_len = 0;
        end
    end
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 16'hDEAD;

    int we_low = 0, oe_low = 0, ce_low = 0;
    always @(negedge clk) begin
        if (!sram_we_n) we_low = we_low + 1;
        if (!sram_oe_n) oe_low = oe_low + 1;
        if (!sram_ce_n) ce_low = ce_low + 1;
    end

    // Reference model state
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_rdata = '0;
    logic [15:0] ref_hex = '0;
    logic [15:0] ref_sw = '0;
    logic [15:0] ref_acc = '0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_sw(input logic [15:0] v);
        sw_i   = v;
        ref_sw = v;
    endtask

    task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                             input int hold_extra);
        int  we0, oe0, ce0, lat;
        bit  is_io;
        is_io = (addr == 16'hFFFF);
        if (is_io && !wr) repeat (2) @(posedge clk);
        @(posedge clk); #1;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = wr;
        mem_addr    = addr;
        mem_wdata   = data;
        we0 = we_low; oe0 = oe_low; ce0 = ce_low;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            mem_addr    = 16'($urandom);
            mem_wdata   = 16'($urandom);
            mem_wr_ena  = 1'($urandom);
            if (mem_ready) break;
        end
        if (wr) begin
            if (is_io) ref_hex = data;
            else       ref_mem[addr] = data;
        end else begin
            if (is_io)                   ref_rdata = ref_sw;
            else if (ref_mem.exists(addr)) ref_rdata = ref_mem[addr];
            else                          ref_rdata = 16'h0000;
        end
        ref_acc = ref_acc + 16'd1;
        check("latency", lat, is_io ? 1 : WS + 1);
        check("rdata_at_ready", mem_rdata, ref_rdata);
        check("hex", hex_o, ref_hex);
        check("we_low_cycles", we_low - we0, (!is_io && wr) ? WS : 0);
        check("oe_low_cycles", oe_low - oe0, (!is_io && !wr) ? WS : 0);
        check("ce_low_cycles", ce_low - ce0, is_io ? 0 : WS);
        if (is_io && !wr) set_sw(16'($urandom));
        for (int k = 0; k < hold_extra; k++) begin
            @(posedge clk); #1;
            check("ready_held", mem_ready, 1'b1);
        end
        mem_mem_ena = 1'b0;
        @(posedge clk); #1;
        check("ready_drop", mem_ready, 1'b0);
        check("rdata_after", mem_rdata, ref_rdata);
`ifdef MEM_IO_ACC_CNT_EN
        check("acc_cnt", acc_cnt, ref_acc);
`endif
    endtask

    initial begin
        logic [15:0] a;
        int          sel;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", mem_ready, 1'b0);
        check("rst_rdata", mem_rdata, 16'h0000);
        check("rst_hex", hex_o, 16'h0000);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_sram_addr", sram_addr, 16'h0000);
        check("rst_sram_wdata", sram_wdata, 16'h0000);
`ifdef MEM_IO_ACC_CNT_EN
        check("rst_acc_cnt", acc_cnt, 16'h0000);
`endif
        reset = 1'b1;
        @(posedge clk); #1;

        do_access(1'b1, 16'h0010, 16'hBEEF, 0);
        do_access(1'b0, 16'h0010, 16'h0000, 0);
        check("sram_readback", mem_rdata, 16'hBEEF);
        do_access(1'b1, 16'hFFFF, 16'h1234, 0);
        check("hex_written", hex_o, 16'h1234);
        set_sw(16'h00A5);
        do_access(1'b0, 16'hFFFF, 16'h0000, 2);
        check("sw_read", mem_rdata, 16'h00A5);

        // Reset while a write is in its first ACCESS cycle.
        @(posedge clk); #1;
        mem_mem_ena = 1'b1; mem_wr_ena = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h5555;
        @(posedge clk); #1;
        check("abort_in_access", {sram_ce_n, sram_we_n}, 2'b00);
        reset = 1'b0;
        mem_mem_ena = 1'b0;
        @(posedge clk); #1;
        check("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("abort_ready", mem_ready, 1'b0);
        check("abort_hex", hex_o, 16'h0000);
        check("abort_rdata", mem_rdata, 16'h0000);
        reset = 1'b1;
        ref_rdata = '0; ref_hex = '0; ref_acc = '0;
        @(posedge clk); #1;
        do_access(1'b0, 16'h0020, 16'h0000, 0);
        check("abort_no_write", mem_rdata, 16'h0000);

        do_access(1'b1, 16'h0003, 16'hA5A5, 5);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 4));
            a   = (sel == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) set_sw(16'($urandom));
            do_access(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
